// File: rtl/fetch_cycle.sv
// ---------------------------------------------------------------------------
// fetch_cycle -- instruction-fetch stage of the 5-stage RV32I pipeline.
//
// Owns the fetch PC, drives a req/ack instruction-memory master port and
// loads the IF/ID register consumed by decode. A one-entry skid buffer
// catches an instruction that returns while decode is stalled, so nothing
// fetched is ever lost or delivered twice. A redirect from execute discards
// every younger instruction, including a response still in flight.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   NOP_INST   instruction placed in IF/ID on bubbles and flushes
//
// Ports
//   i_fetch_clk          clock
//   i_fetch_reset        asynchronous, active-high reset
//   i_fetch_stall        hold IF/ID and stop the PC advancing
//   i_fetch_redirect     flush and restart at i_fetch_redirect_pc
//   i_fetch_redirect_pc  redirect target (word aligned)
//   o_fetch_imem_req     instruction-memory request
//   o_fetch_imem_addr    request address, stable while req=1 and ack=0
//   i_fetch_imem_ack     read data valid (may coincide with req: zero wait)
//   i_fetch_imem_rdata   instruction word
//   o_fetch_pc_de        IF/ID pc
//   o_fetch_inst_de      IF/ID instruction
//   o_fetch_insn_vld_de  IF/ID valid
//
// Optional build macro FETCH_PERF_CNT_EN adds
//   o_fetch_inst_cnt     cycles in which IF/ID loaded a valid instruction
//   o_fetch_bubble_cnt   unstalled cycles in which IF/ID loaded a bubble
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_fetch_clk,
  input  logic        i_fetch_reset,
  input  logic        i_fetch_stall,
  input  logic        i_fetch_redirect,
  input  logic [31:0] i_fetch_redirect_pc,
  output logic        o_fetch_imem_req,
  output logic [31:0] o_fetch_imem_addr,
  input  logic        i_fetch_imem_ack,
  input  logic [31:0] i_fetch_imem_rdata,
  output logic [31:0] o_fetch_pc_de,
  output logic [31:0] o_fetch_inst_de,
  output logic        o_fetch_insn_vld_de
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_inst_cnt,
  output logic [31:0] o_fetch_bubble_cnt
`endif
);

  // S_FETCH : request at pc_q, deliver the response straight into IF/ID
  // S_HOLD  : a response arrived under stall and sits in the skid buffer
  // S_DROP  : a redirect overtook an outstanding request; wait out its ack
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;        // next address to fetch
  logic [31:0] req_addr_q;  // address currently presented to memory
  logic        req_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_inst_q;
  logic        skid_full_q;

  logic [31:0] pc_inc;
  logic        deliver_fetch;
  logic        deliver_skid;

  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0 by plain truncation.
  assign pc_inc = pc_q + 32'd4;

  // Candidate IF/ID sources; redirect and stall priority is applied where
  // the IF/ID register is written.
  assign deliver_fetch = (state_q == S_FETCH) && i_fetch_imem_ack;
  assign deliver_skid  = (state_q == S_HOLD) && skid_full_q;

  // req and addr come straight from flops so the memory sees glitch-free,
  // stable request signals. In S_FETCH and S_HOLD req_addr_q always equals
  // pc_q; only S_DROP lets them diverge.
  assign o_fetch_imem_req  = req_q;
  assign o_fetch_imem_addr = req_addr_q;

  // -------------------------------------------------------------------------
  // Fetch control FSM: state, PC, request registers and skid buffer.
  // -------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking (<=) assignments so all
  // flops sample the pre-edge values; blocking here would create order races.
  always_ff @(posedge i_fetch_clk or posedge i_fetch_reset) begin
    if (i_fetch_reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_q       <= 1'b1;
      // NOTE: the skid data fields are reset as well; they are only a few
      // flops and this keeps X out of IF/ID even before the first stall.
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      skid_full_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (i_fetch_imem_ack) begin
            if (i_fetch_redirect) begin
              // Response belongs to the squashed path: drop it.
              pc_q       <= i_fetch_redirect_pc;
              req_addr_q <= i_fetch_redirect_pc;
            end else begin
              pc_q       <= pc_inc;
              req_addr_q <= pc_inc;
              if (i_fetch_stall) begin
                // Decode cannot take it: park it and stop requesting.
                skid_pc_q   <= pc_q;
                skid_inst_q <= i_fetch_imem_rdata;
                skid_full_q <= 1'b1;
                req_q       <= 1'b0;
                state_q     <= S_HOLD;
              end
            end
          end else if (i_fetch_redirect) begin
            // The old request must stay on the bus until acked, so
            // req_addr_q keeps pc_q while pc_q moves to the target.
            pc_q    <= i_fetch_redirect_pc;
            state_q <= S_DROP;
          end
        end

        S_HOLD: begin
          if (i_fetch_redirect) begin
            pc_q        <= i_fetch_redirect_pc;
            req_addr_q  <= i_fetch_redirect_pc;
            skid_full_q <= 1'b0;
            req_q       <= 1'b1;
            state_q     <= S_FETCH;
          end else if (!i_fetch_stall) begin
            // Skid drains into IF/ID this edge; pc_q already points past it.
            skid_full_q <= 1'b0;
            req_q       <= 1'b1;
            state_q     <= S_FETCH;
          end
        end

        S_DROP: begin
          if (i_fetch_redirect) begin
            pc_q <= i_fetch_redirect_pc;
          end
          if (i_fetch_imem_ack) begin
            // Stale response discarded; resume at the latest target.
            req_addr_q <= i_fetch_redirect ? i_fetch_redirect_pc : pc_q;
            state_q    <= S_FETCH;
          end
        end

        default: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // IF/ID register. Priority: redirect flush, stall hold, delivery, bubble.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_fetch_clk or posedge i_fetch_reset) begin
    if (i_fetch_reset) begin
      o_fetch_pc_de       <= '0;
      o_fetch_inst_de     <= NOP_INST;
      o_fetch_insn_vld_de <= 1'b0;
    end else if (i_fetch_redirect) begin
      o_fetch_pc_de       <= '0;
      o_fetch_inst_de     <= NOP_INST;
      o_fetch_insn_vld_de <= 1'b0;
    end else if (!i_fetch_stall) begin
      if (deliver_fetch) begin
        o_fetch_pc_de       <= pc_q;
        o_fetch_inst_de     <= i_fetch_imem_rdata;
        o_fetch_insn_vld_de <= 1'b1;
      end else if (deliver_skid) begin
        o_fetch_pc_de       <= skid_pc_q;
        o_fetch_inst_de     <= skid_inst_q;
        o_fetch_insn_vld_de <= 1'b1;
      end else begin
        o_fetch_pc_de       <= '0;
        o_fetch_inst_de     <= NOP_INST;
        o_fetch_insn_vld_de <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counters, both free-running modulo 2^32.
  // -------------------------------------------------------------------------
  logic        load_vld;
  logic        load_bubble;
  logic [31:0] inst_cnt_q;
  logic [31:0] bubble_cnt_q;

  assign load_vld    = !i_fetch_redirect && !i_fetch_stall &&
                       (deliver_fetch || deliver_skid);
  // A flush under stall still loads a bubble but is not counted: bubbles
  // are only charged to cycles where decode was actually able to accept.
  assign load_bubble = !i_fetch_stall && !load_vld;

  always_ff @(posedge i_fetch_clk or posedge i_fetch_reset) begin
    if (i_fetch_reset) begin
      inst_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_vld) begin
        inst_cnt_q <= inst_cnt_q + 32'd1;
      end
      if (load_bubble) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign o_fetch_inst_cnt   = inst_cnt_q;
  assign o_fetch_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// ---------------------------------------------------------------------------
// tb_fetch_cycle -- self-checking bench for fetch_cycle.
//
// A behavioural memory answers requests with a random (or fixed) latency of
// 0..2 cycles and returns mem_word(addr). The stimulus side keeps a queue of
// the program-order PCs that decode must see next; a redirect restarts that
// queue at the target. An independent monitor pops the queue on every valid
// IF/ID load and also checks flush, hold, bubble and request stability.
// Build with +define+FETCH_PERF_CNT_EN to exercise the performance counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fetch_cycle;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req;
  logic [31:0] addr;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] pc_de;
  logic [31:0] inst_de;
  logic        vld_de;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] inst_cnt;
  logic [31:0] bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  fetch_cycle #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) dut (
    .i_fetch_clk         (clk),
    .i_fetch_reset       (rst),
    .i_fetch_stall       (stall),
    .i_fetch_redirect    (redirect),
    .i_fetch_redirect_pc (redirect_pc),
    .o_fetch_imem_req    (req),
    .o_fetch_imem_addr   (addr),
    .i_fetch_imem_ack    (ack),
    .i_fetch_imem_rdata  (rdata),
    .o_fetch_pc_de       (pc_de),
    .o_fetch_inst_de     (inst_de),
    .o_fetch_insn_vld_de (vld_de)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_inst_cnt    (inst_cnt),
    .o_fetch_bubble_cnt  (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1234_5000;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ------------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;

  task automatic sb_fill();
    while (exp_q.size() < 64) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    exp_tail = start;
    sb_fill();
  endtask

  // ----------------------------------------------------------------- memory
  int lat_fixed = 0;  // <0 selects a random latency per request
  int mem_cnt = 0;
  int mem_lat = 0;

  function automatic int pick_lat();
    return (lat_fixed < 0) ? int'($urandom_range(0, 2)) : lat_fixed;
  endfunction

  // Decides ack just after the falling edge, while req/addr (flops) are
  // stable, so a zero-latency ack lands in the same cycle as its request.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        ack     = 1'b0;
        mem_cnt = 0;
        mem_lat = pick_lat();
      end else if (req) begin
        if (mem_cnt >= mem_lat) begin
          ack     = 1'b1;
          rdata   = mem_word(addr);
          mem_cnt = 0;
          mem_lat = pick_lat();
        end else begin
          ack     = 1'b0;
          rdata   = 32'hDEAD_BEEF;
          mem_cnt++;
        end
      end else begin
        ack   = 1'b0;
        rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  logic [31:0] p_pc, p_inst, p_addr;
  logic        p_vld, p_req;
  logic [31:0] e_pc;
  int          idle = 0;
  int unsigned m_inst = 0;
  int unsigned m_bub  = 0;

  initial begin
    forever begin
      tick();
      if (rst) begin
        idle   = 0;
        m_inst = 0;
        m_bub  = 0;
      end else begin
        if (p_req && !ack) begin
          check1("req_held", req, 1'b1);
          check("addr_held", addr, p_addr);
        end
        if (redirect) begin
          check1("flush_vld", vld_de, 1'b0);
          check("flush_pc", pc_de, 32'h0);
          check("flush_inst", inst_de, NOP_INST);
        end else if (stall) begin
          check1("hold_vld", vld_de, p_vld);
          check("hold_pc", pc_de, p_pc);
          check("hold_inst", inst_de, p_inst);
        end else if (vld_de) begin
          idle = 0;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: delivered pc %h with no expectation", pc_de);
          end else begin
            e_pc = exp_q.pop_front();
            check("deliver_pc", pc_de, e_pc);
            check("deliver_inst", inst_de, mem_word(e_pc));
          end
        end else begin
          idle++;
          check("bubble_pc", pc_de, 32'h0);
          check("bubble_inst", inst_de, NOP_INST);
        end
        if (idle > 60) begin
          tests++;
          fails++;
          $display("FAIL liveness: %0d unstalled cycles without delivery", idle);
          idle = 0;
        end
`ifdef FETCH_PERF_CNT_EN
        if (!stall) begin
          if (!redirect && vld_de) m_inst++;
          else                     m_bub++;
        end
        check("perf_inst_track", inst_cnt, m_inst);
        check("perf_bubble_track", bubble_cnt, m_bub);
`endif
      end
      p_pc   = pc_de;
      p_inst = inst_de;
      p_vld  = vld_de;
      p_req  = req;
      p_addr = addr;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic do_reset(input int lat);
    @(negedge clk);
    lat_fixed   = lat;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    exp_q.delete();
    tick();
    tick();
    check1("rst_vld", vld_de, 1'b0);
    check("rst_pc", pc_de, 32'h0);
    check("rst_inst", inst_de, NOP_INST);
    check1("rst_req", req, 1'b1);
    check("rst_addr", addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
    check("rst_inst_cnt", inst_cnt, 32'h0);
    check("rst_bubble_cnt", bubble_cnt, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    sb_restart(RESET_PC);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 255)) << 2;
      2:       return 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      default: return $urandom & ~32'h3;
    endcase
  endfunction

  initial begin
    int seen;

    // Zero-wait sequential fetch: one request and one delivery per cycle.
    do_reset(0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("seq_addr", addr, 32'(k * 4));
      check("seq_pc", pc_de, 32'((k - 1) * 4));
      check1("seq_vld", vld_de, 1'b1);
    end

    // Stall for three cycles while the response for pc 8 arrives.
    do_reset(0);
    tick();
    tick();
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check1("stall_req", req, 1'b0);
      check("stall_pc", pc_de, 32'h4);
    end
    @(negedge clk);
    stall = 1'b0;
    tick();
    check("drain_pc", pc_de, 32'h8);
    check1("drain_vld", vld_de, 1'b1);
    check1("drain_req", req, 1'b1);
    check("drain_addr", addr, 32'hC);
    tick();
    check("after_drain_pc", pc_de, 32'hC);

    // Two-cycle memory; redirect to 0x100 while 0x20 is outstanding.
    do_reset(2);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h20;
    sb_restart(32'h20);
    tick();
    @(negedge clk);
    redirect = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      tick();
      if (req && addr == 32'h20) seen = 1;
    end
    check("reach_0x20", 32'(seen), 32'h1);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    sb_restart(32'h100);
    tick();
    check("drop_addr", addr, 32'h20);
    @(negedge clk);
    redirect = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      tick();
      if (addr == 32'h100) seen = 1;
      else check("drop_addr_held", addr, 32'h20);
      check1("drop_no_vld", vld_de, 1'b0);
    end
    check("drop_next_addr", 32'(seen), 32'h1);
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      tick();
      if (vld_de) seen = 1;
      else check("drop_bubble", inst_de, NOP_INST);
    end
    check("drop_first_pc", pc_de, 32'h100);
    check("drop_first_inst", inst_de, mem_word(32'h100));

    // Redirect and stall together: redirect wins.
    do_reset(0);
    tick();
    tick();
    tick();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    stall = 1'b1;
    sb_restart(32'h40);
    tick();
    check("rs_pc", pc_de, 32'h0);
    check("rs_inst", inst_de, NOP_INST);
    check1("rs_vld", vld_de, 1'b0);
    check("rs_addr", addr, 32'h40);
    @(negedge clk);
    redirect = 1'b0;
    stall = 1'b0;
    tick();
    check("rs_deliver", pc_de, 32'h40);

    // PC wrap at the top of the address space.
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sb_restart(32'hFFFF_FFFC);
    tick();
    check("wrap_req", addr, 32'hFFFF_FFFC);
    @(negedge clk);
    redirect = 1'b0;
    tick();
    check("wrap_addr", addr, 32'h0);
    check("wrap_pc", pc_de, 32'hFFFF_FFFC);
    tick();
    check("wrap_next_pc", pc_de, 32'h0);

    // Randomised traffic: random latency, stalls, redirects, one reset.
    lat_fixed = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset(-1);
      end else begin
        @(negedge clk);
        stall = ($urandom_range(0, 99) < 25);
        if ($urandom_range(0, 99) < 3) begin
          redirect    = 1'b1;
          redirect_pc = pick_target();
          sb_restart(redirect_pc);
        end else begin
          redirect = 1'b0;
          sb_fill();
        end
      end
    end
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    for (int c = 0; c < 20; c++) tick();

`ifdef FETCH_PERF_CNT_EN
    // Ten valid deliveries and two redirect flushes.
    do_reset(0);
    for (int k = 0; k < 5; k++) tick();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    sb_restart(32'h200);
    tick();
    @(negedge clk);
    redirect = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    sb_restart(32'h300);
    tick();
    check("perf_inst_10", inst_cnt, 32'd10);
    check1("perf_bubble_ge2", bubble_cnt >= 32'd2, 1'b1);
    @(negedge clk);
    redirect = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so a hung DUT still ends the run.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
- Front end of the 5-stage RV32I pipeline; produces the PC/instruction stream consumed by the decode stage.
- Owns the fetch PC and a req/ack instruction-memory master port.
- Holds a 1-entry skid buffer so an instruction returned during a stall is never lost.
- Drives the IF/ID register (pc, inst, valid) and obeys stall from the hazard unit and redirect (taken branch/jump) from execute.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction injected on bubbles and flushes (addi x0,x0,0).

Ports:
- i_fetch_clk  in  1  clock.
- i_fetch_reset  in  1  asynchronous, active-high reset.
- i_fetch_stall  in  1  hold IF/ID contents and stop PC advance.
- i_fetch_redirect  in  1  flush younger instructions and restart at i_fetch_redirect_pc.
- i_fetch_redirect_pc  in  32  redirect target, word aligned.
- o_fetch_imem_req  out  1  instruction-memory request.
- o_fetch_imem_addr  out  32  request address; stable while req=1 and ack=0.
- i_fetch_imem_ack  in  1  rdata valid; may assert in the same cycle as req (zero wait).
- i_fetch_imem_rdata  in  32  instruction word.
- o_fetch_pc_de  out  32  IF/ID pc.
- o_fetch_inst_de  out  32  IF/ID instruction.
- o_fetch_insn_vld_de  out  1  IF/ID instruction valid.

Behaviour:
- Registers:
  - pc_q: next address to fetch.
  - req_addr_q: address of the outstanding request.
  - skid_q: {pc, inst, full}.
  - State: S_FETCH, S_HOLD, S_DROP.
- Reset (async):
  - pc_q = req_addr_q = RESET_PC; state = S_FETCH; skid empty.
  - o_fetch_pc_de = 0, o_fetch_inst_de = NOP_INST, o_fetch_insn_vld_de = 0.
- S_FETCH: req = 1, addr = pc_q.
  - ack & redirect: discard rdata; pc_q <= redirect_pc.
  - ack & !redirect & !stall: IF/ID <= {pc_q, rdata, 1}; pc_q <= pc_q+4.
  - ack & !redirect & stall: skid <= {pc_q, rdata}; pc_q <= pc_q+4; go S_HOLD.
  - !ack & redirect: req_addr_q <= pc_q; pc_q <= redirect_pc; go S_DROP.
- S_HOLD: req = 0; skid full.
  - redirect: clear skid; pc_q <= redirect_pc; go S_FETCH.
  - !stall: IF/ID <= skid; clear skid; go S_FETCH.
  - stall: remain in S_HOLD.
- S_DROP: req = 1, addr = req_addr_q (old request held until ack).
  - A further redirect overwrites pc_q.
  - On ack: discard rdata; go S_FETCH.
- IF/ID update, in priority order:
  1. redirect: {0, NOP_INST, 0}.
  2. stall: hold.
  3. delivery (ack in S_FETCH, or skid drain): load.
  4. otherwise: bubble {0, NOP_INST, 0}.
- Redirect beats stall in the same cycle.
- pc increment is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Latency: with zero-wait memory, the instruction at P appears on IF/ID the cycle after the request for P. Sustained throughput is 1 instruction/cycle.
- A dropped response never reaches IF/ID. No instruction is delivered twice or skipped across a stall.
- Reset mid-request: the outstanding ack is not tracked. The memory is reset by the same reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs o_fetch_inst_cnt[31:0] and o_fetch_bubble_cnt[31:0].
  - Both reset to 0 and wrap at 2^32.
  - inst_cnt +1 on each cycle IF/ID loads valid=1.
  - bubble_cnt +1 on each cycle IF/ID loads valid=0 while not stalled.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, zero-wait memory, ack tied high -> req addr 0,4,8,... each cycle; IF/ID pc 0 then 4 then 8, vld=1 from cycle 2.
- Stall held 3 cycles while ack arrives for pc 8 -> state S_HOLD, req=0, IF/ID holds pc 4. After release, IF/ID pc 8, then a request for 12; no instruction lost or duplicated.
- Memory with 2-cycle latency; redirect to 0x100 one cycle after req for 0x20 -> addr stays 0x20 until ack; that rdata is discarded; next req addr 0x100; IF/ID shows vld=0 NOP until the 0x100 instruction.
- Redirect to 0x40 and stall in the same cycle -> IF/ID = {0, 0x00000013, 0}; next req addr 0x40.
- pc_q = 32'hFFFF_FFFC, ack -> next req addr 32'h0000_0000.
- FETCH_PERF_CNT_EN defined: 10 valid deliveries plus 2 redirect flushes -> inst_cnt = 10, bubble_cnt ≥ 2.
